// File: rtl/disp_pkg.sv
// Shared seven-segment display definitions: blank patterns and the hex decode
// table used by every display block in the codebase.
package disp_pkg;

    // Largest digit count any display block instantiates; AN_OFF is sliced to size.
    localparam int MAX_DIG = 16;

    // Active-low segments: all ones means every segment is dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low anodes: all ones means no digit is selected.
    localparam logic [MAX_DIG-1:0] AN_OFF = '1;

    // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex to active-low seven-segment decode.
module hex_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = hex2seg(i_hex);

endmodule

// File: rtl/anode_scan_ctrl.sv
// Time-multiplexed seven-segment scanner. A prescaler sets how long each digit
// stays lit; the input word is snapshotted once per frame so a register write
// in the middle of a scan never shows half old, half new digits.
module anode_scan_ctrl
    import disp_pkg::*;
#(
    parameter int ANCHO       = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**ANCHO-1:0]   data_in,
    input  logic                  en,
    input  logic                  blank_lz,
    output logic [2**ANCHO/4-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_st
);

    localparam int DW    = 2**ANCHO;
    localparam int NDIG  = DW / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [PRE_W-1:0] r_presc;
    logic [IDX_W-1:0] r_idx;
    logic [DW-1:0]    r_snap;
    logic             r_first;
    logic             r_frame_st;
    logic [NDIG-1:0]  r_an;
    logic [6:0]       r_seg;

    logic             w_tick;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg;
    logic             w_upper_zero;
    logic             w_blank;
    logic [NDIG-1:0]  w_an_sel;

    assign w_tick = (r_presc == PRE_LAST);

    // Prescaler: free-running 0..REFRESH_DIV-1, tick on the last count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst)
            r_presc <= '0;
        else if (w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    // Digit index advance, per-frame snapshot and frame-start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_snap     <= '0;
            r_first    <= 1'b1;
            r_frame_st <= 1'b0;
        end else begin
            r_frame_st <= 1'b0;
            if (w_tick) begin
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                r_first <= 1'b0;
                if (r_idx == IDX_LAST || r_first) begin
                    r_snap     <= data_in;
                    r_frame_st <= 1'b1;
                end
            end
        end
    end

    assign w_nib        = r_snap[{r_idx, 2'b00} +: 4];
    assign w_upper_zero = ((r_snap >> {r_idx, 2'b00}) == '0);
    assign w_blank      = blank_lz && (r_idx != '0) && w_upper_zero;
    assign w_an_sel     = ~(NDIG'(1) << r_idx);

    hex_to_seg u_hex_to_seg (
        .i_hex (w_nib),
        .o_seg (w_seg)
    );

    // Registered pin drivers, refreshed every cycle from the current idx/snapshot.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_an  <= AN_OFF[NDIG-1:0];
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= w_an_sel;
            r_seg <= w_blank ? SEG_OFF : w_seg;
        end
    end

    assign an       = r_an;
    assign seg      = r_seg;
    assign dp       = 1'b1;
    assign frame_st = r_frame_st;

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Self-checking bench for anode_scan_ctrl (ANCHO=4, REFRESH_DIV=4): a cycle
// count based reference model checked on every negedge, plus literal frame checks.
module tb_anode_scan_ctrl;

    localparam int ANCHO = 4;
    localparam int D     = 4;
    localparam int NDIG  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        en;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_st;

    int checks = 0;
    int errors = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] an_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    anode_scan_ctrl #(.ANCHO(ANCHO), .REFRESH_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .en       (en),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .frame_st (frame_st)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n = clock edges since reset released; digit = (n/D) mod NDIG.
    int          m_n;
    bit          m_valid = 1'b0;
    logic [15:0] m_snap;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fst;
    int          m_cur;
    int          m_prior;

    always @(posedge clk) begin
        if (rst) begin
            m_n     = 0;
            m_snap  = 16'h0;
            e_an    = 4'hF;
            e_seg   = 7'h7F;
            e_fst   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_cur = (m_n / D) % NDIG;
            if (en) begin
                e_an = ~(4'b0001 << m_cur);
                if (blank_lz && m_cur > 0 && (m_snap >> (4 * m_cur)) == 16'h0)
                    e_seg = 7'h7F;
                else
                    e_seg = tbl[m_snap[m_cur*4 +: 4]];
            end else begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
            end
            m_n++;
            e_fst = 1'b0;
            if (m_n % D == 0) begin
                m_prior = ((m_n - 1) / D) % NDIG;
                if (m_prior == NDIG - 1 || m_n == D) begin
                    m_snap = data_in;
                    e_fst  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_an", an, e_an);
            check("model_seg", seg, e_seg);
            check("model_dp", dp, 1'b1);
            check("model_frame_st", frame_st, e_fst);
        end
    end

    task automatic wait_frame();
        int k;
        for (k = 0; k < 200 && frame_st !== 1'b1; k++) @(negedge clk);
        if (frame_st !== 1'b1) check("frame_st_timeout", frame_st, 1'b1);
    endtask

    // Waits for frame start, then checks every slot of the following frame.
    // Optionally writes wr_val to data_in at the start of digit wr_digit.
    task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input int wr_digit, input logic [15:0] wr_val);
        logic [6:0] exp_seg [4];
        exp_seg = '{s0, s1, s2, s3};
        wait_frame();
        for (int i = 0; i < NDIG; i++) begin
            if (i == wr_digit) data_in = wr_val;
            for (int j = 0; j < D; j++) begin
                @(negedge clk);
                check($sformatf("lit_an_d%0d", i), an, an_lit[i]);
                check($sformatf("lit_seg_d%0d", i), seg, exp_seg[i]);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        blank_lz = 1'b0;
        data_in  = 16'h1234;

        // Reset held three cycles, outputs at reset values during and after.
        repeat (3) begin
            @(negedge clk);
            check("rst_an", an, 4'hF);
            check("rst_seg", seg, 7'h7F);
            check("rst_dp", dp, 1'b1);
            check("rst_frame_st", frame_st, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_an", an, 4'hF);
        check("post_rst_seg", seg, 7'h7F);
        check("post_rst_frame_st", frame_st, 1'b0);
        en = 1'b1;

        // First frame_st comes on the first tick after reset.
        wait_frame();
        @(negedge clk);

        // Plain scan of 1234, then a write of ABCD in the middle of a frame.
        check_frame(7'h19, 7'h30, 7'h24, 7'h79, -1, 16'h0);
        check_frame(7'h19, 7'h30, 7'h24, 7'h79, 2, 16'hABCD);
        check_frame(7'h21, 7'h46, 7'h03, 7'h08, -1, 16'h0);

        // Leading-zero blanking.
        data_in  = 16'h0050;
        blank_lz = 1'b1;
        @(negedge clk);
        check_frame(7'h40, 7'h12, 7'h7F, 7'h7F, -1, 16'h0);
        data_in = 16'h0000;
        @(negedge clk);
        check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0);

        // Display disabled mid-frame; scan must resume in phase.
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en0_an", an, 4'hF);
        check("en0_seg", seg, 7'h7F);
        repeat (9) @(negedge clk);
        en = 1'b1;
        check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, -1, 16'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) data_in = 16'($urandom);
            if ($urandom_range(15) == 0) en = ~en;
            if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(3) == 0) data_in[15:8] = 8'h00;
        end

        // Reset pulse mid-frame.
        en = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_frame_st", frame_st, 1'b0);
        rst = 1'b0;

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ($urandom_range(5) == 0) data_in = 16'($urandom);
            if ($urandom_range(15) == 0) en = ~en;
            if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
